// File: rtl/unet_bn_pkg.sv
// Shared definitions for the UNET batch-norm + activation engine.
// Holds default widths, mode and FSM state encodings, the signed
// saturation helper and the clamped-ReLU ceiling.
package unet_bn_pkg;

    localparam int unsigned DATA_W_DEF = 12;
    localparam int unsigned FRAC_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 15;
    localparam int unsigned DIM_W_DEF  = 7;
    localparam int unsigned CH_MAX_DEF = 64;

    // Activation select
    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_RELU   = 2'd1,
        MODE_LEAKY  = 2'd2,
        MODE_RELU6  = 2'd3
    } mode_t;

    // Pass sequencing
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                                 input int unsigned        w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] r;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        r  = v;
        if (v > hi) begin
            r = hi;
        end else if (v < lo) begin
            r = lo;
        end
        return r;
    endfunction

    // 6.0 expressed with frac_w fractional bits.
    function automatic int relu6_q(input int unsigned frac_w);
        return 6 << frac_w;
    endfunction

    localparam int RELU6_Q = relu6_q(FRAC_W_DEF);

endpackage

// File: rtl/unet_bn_datapath.sv
// Two-stage scale/bias/activate pipeline.
// Stage 1 registers x*scale together with valid, channel and write address.
// Stage 2 floors the product, adds the channel bias, saturates, applies the
// activation and registers the result straight onto the SRAM write port.
// Ports: clk, arst_n, mode, in_valid/in_ch/in_addr/x (element entering
// stage 1), scale (coefficient for in_ch), bias_ch_c (channel held in
// stage 1, used to look up bias), bias, out_valid/out_addr/out_data.
module unet_bn_datapath
    import unet_bn_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CH_AW  = 6
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  mode_t                    mode,
    input  logic                     in_valid,
    input  logic [CH_AW-1:0]         in_ch,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] scale,
    output logic [CH_AW-1:0]         bias_ch_c,
    input  logic signed [DATA_W-1:0] bias,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_addr,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int unsigned P_W = 2 * DATA_W;
    localparam int unsigned S_W = P_W + 1;
    localparam logic signed [DATA_W-1:0] RELU6_LIM = DATA_W'(relu6_q(FRAC_W));

    logic signed [P_W-1:0]    prod_c;
    logic signed [P_W-1:0]    prod_q;
    logic                     s1_valid;
    logic [CH_AW-1:0]         s1_ch;
    logic [ADDR_W-1:0]        s1_addr;
    logic signed [P_W-1:0]    shr_c;
    logic signed [S_W-1:0]    sum_c;
    logic signed [DATA_W-1:0] y_c;
    logic signed [DATA_W-1:0] act_c;

    // Full-width signed product
    assign prod_c = P_W'(x) * P_W'(scale);

    // Stage 1: product and sideband
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            prod_q   <= '0;
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                prod_q  <= prod_c;
                s1_ch   <= in_ch;
                s1_addr <= in_addr;
            end
        end
    end

    assign bias_ch_c = s1_ch;

    // Arithmetic shift floors toward negative infinity
    assign shr_c = prod_q >>> FRAC_W;
    assign sum_c = S_W'(shr_c) + S_W'(bias);
    assign y_c   = DATA_W'(sat_w(64'(sum_c), DATA_W));

    // Activation on the saturated value
    always_comb begin
        act_c = y_c;
        case (mode)
            MODE_BYPASS: act_c = y_c;
            MODE_RELU: begin
                if (y_c[DATA_W-1]) act_c = '0;
            end
            MODE_LEAKY: begin
                if (y_c[DATA_W-1]) act_c = y_c >>> 3;
            end
            MODE_RELU6: begin
                if (y_c[DATA_W-1]) begin
                    act_c = '0;
                end else if (y_c > RELU6_LIM) begin
                    act_c = RELU6_LIM;
                end
            end
            default: act_c = y_c;
        endcase
    end

    // Stage 2: result onto the write port
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_addr <= s1_addr;
                out_data <= act_c;
            end
        end
    end

endmodule

// File: rtl/unet_bn_act.sv
// Streaming batch-norm + activation engine.
// Reads a channel-major map from the input SRAM, applies per-channel
// scale/bias from an internal table and the selected activation, and writes
// one element per cycle to the output SRAM with a 3-cycle read-to-write lag.
// Ports: clk, arst_n; start/busy/done/err pass control; mode, channels,
// height, width, in_base, out_base pass setup; cfg_* coefficient writes;
// input_rsc_* read port; output_rsc_* write port; *_triosy_lz end-of-pass.
module unet_bn_act
    import unet_bn_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned FRAC_W = FRAC_W_DEF,
    parameter  int unsigned ADDR_W = ADDR_W_DEF,
    parameter  int unsigned DIM_W  = DIM_W_DEF,
    parameter  int unsigned CH_MAX = CH_MAX_DEF,
    localparam int unsigned CH_AW  = (CH_MAX > 1) ? $clog2(CH_MAX) : 1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic [1:0]               mode,
    input  logic [DIM_W-1:0]         channels,
    input  logic [DIM_W-1:0]         height,
    input  logic [DIM_W-1:0]         width,
    input  logic [ADDR_W-1:0]        in_base,
    input  logic [ADDR_W-1:0]        out_base,
    input  logic                     cfg_we,
    input  logic [CH_AW-1:0]         cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_scale,
    input  logic signed [DATA_W-1:0] cfg_bias,
    output logic [ADDR_W-1:0]        input_rsc_radr,
    output logic                     input_rsc_re,
    input  logic signed [DATA_W-1:0] input_rsc_q,
    output logic                     input_rsc_clken,
    output logic                     input_triosy_lz,
    output logic [ADDR_W-1:0]        output_rsc_wadr,
    output logic signed [DATA_W-1:0] output_rsc_d,
    output logic                     output_rsc_we,
    output logic                     output_rsc_clken,
    output logic                     output_triosy_lz
);

    localparam int unsigned HW_W = 2 * DIM_W;
    localparam int unsigned N_W  = 3 * DIM_W;

    state_t              state_q;
    state_t              state_nx;
    mode_t               mode_q;
    logic [HW_W-1:0]     hw_c;
    logic [N_W-1:0]      n_c;
    logic                too_many_c;
    logic                empty_c;
    logic [HW_W-1:0]     hw_last_q;
    logic [HW_W-1:0]     pix_q;
    logic [CH_AW-1:0]    ch_q;
    logic [N_W-1:0]      rem_q;
    logic [ADDR_W-1:0]   rd_wadr_q;
    logic [1:0]          drain_q;
    logic                d_vld_q;
    logic [CH_AW-1:0]    d_ch_q;
    logic [ADDR_W-1:0]   d_wadr_q;
    logic [CH_AW-1:0]    bias_ch_c;
    logic signed [DATA_W-1:0] scale_c;
    logic signed [DATA_W-1:0] bias_c;
    logic signed [DATA_W-1:0] scale_tab [CH_MAX];
    logic signed [DATA_W-1:0] bias_tab  [CH_MAX];

    // Pass geometry from the live setup inputs
    assign hw_c       = HW_W'(height) * HW_W'(width);
    assign n_c        = N_W'(channels) * N_W'(hw_c);
    assign too_many_c = 32'(channels) > CH_MAX;
    assign empty_c    = (n_c == '0);

    // Next-state decode
    always_comb begin
        state_nx = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (too_many_c || empty_c) state_nx = ST_DONE;
                    else                       state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rem_q == '0) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_q == 2'd0) state_nx = ST_DONE;
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // State, counters and read-port registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q        <= ST_IDLE;
            mode_q         <= MODE_BYPASS;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            hw_last_q      <= '0;
            pix_q          <= '0;
            ch_q           <= '0;
            rem_q          <= '0;
            rd_wadr_q      <= '0;
            drain_q        <= '0;
            input_rsc_re   <= 1'b0;
            input_rsc_radr <= '0;
        end else begin
            state_q <= state_nx;
            busy    <= (state_nx == ST_RUN) || (state_nx == ST_DRAIN);
            done    <= (state_nx == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q         <= mode_t'(mode);
                        err            <= too_many_c;
                        hw_last_q      <= hw_c - HW_W'(1);
                        rem_q          <= n_c - N_W'(1);
                        pix_q          <= '0;
                        ch_q           <= '0;
                        input_rsc_radr <= in_base;
                        rd_wadr_q      <= out_base;
                        input_rsc_re   <= (state_nx == ST_RUN);
                    end
                end
                ST_RUN: begin
                    if (rem_q == '0) begin
                        input_rsc_re <= 1'b0;
                        drain_q      <= 2'd2;
                    end else begin
                        rem_q          <= rem_q - N_W'(1);
                        input_rsc_radr <= input_rsc_radr + ADDR_W'(1);
                        rd_wadr_q      <= rd_wadr_q + ADDR_W'(1);
                        // Channel advances when the pixel counter rolls over
                        if (pix_q == hw_last_q) begin
                            pix_q <= '0;
                            ch_q  <= ch_q + CH_AW'(1);
                        end else begin
                            pix_q <= pix_q + HW_W'(1);
                        end
                    end
                end
                ST_DRAIN: drain_q <= drain_q - 2'd1;
                default: ;
            endcase
        end
    end

    // Align channel/address sideband with the SRAM read data
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            d_vld_q  <= 1'b0;
            d_ch_q   <= '0;
            d_wadr_q <= '0;
        end else begin
            d_vld_q  <= input_rsc_re;
            d_ch_q   <= ch_q;
            d_wadr_q <= rd_wadr_q;
        end
    end

    // Coefficient table, writable only while idle; contents not reset
    always_ff @(posedge clk) begin
        if (cfg_we && (state_q == ST_IDLE)) begin
            scale_tab[cfg_addr] <= cfg_scale;
            bias_tab[cfg_addr]  <= cfg_bias;
        end
    end

    assign scale_c = scale_tab[d_ch_q];
    assign bias_c  = bias_tab[bias_ch_c];

    unet_bn_datapath #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ADDR_W (ADDR_W),
        .CH_AW  (CH_AW)
    ) u_datapath (
        .clk       (clk),
        .arst_n    (arst_n),
        .mode      (mode_q),
        .in_valid  (d_vld_q),
        .in_ch     (d_ch_q),
        .in_addr   (d_wadr_q),
        .x         (input_rsc_q),
        .scale     (scale_c),
        .bias_ch_c (bias_ch_c),
        .bias      (bias_c),
        .out_valid (output_rsc_we),
        .out_addr  (output_rsc_wadr),
        .out_data  (output_rsc_d)
    );

    assign input_rsc_clken  = input_rsc_re;
    assign output_rsc_clken = output_rsc_we;
    assign input_triosy_lz  = done;
    assign output_triosy_lz = done;

endmodule

// File: tb/tb_unet_bn_act.sv
// Scoreboard bench for unet_bn_act: directed passes push expected writes,
// a negedge monitor pops and compares address, data and cycle.
module tb_unet_bn_act;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DIM_W  = 7;
    localparam int unsigned CH_AW  = 6;
    localparam int          AMOD   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, err;
    logic [1:0]        mode = '0;
    logic [DIM_W-1:0]  channels = '0, height = '0, width = '0;
    logic [ADDR_W-1:0] in_base = '0, out_base = '0;
    logic              cfg_we = 1'b0;
    logic [CH_AW-1:0]  cfg_addr = '0;
    logic [DATA_W-1:0] cfg_scale = '0, cfg_bias = '0;
    logic [ADDR_W-1:0] input_rsc_radr;
    logic              input_rsc_re, input_rsc_clken, input_triosy_lz;
    logic [DATA_W-1:0] input_rsc_q = '0;
    logic [ADDR_W-1:0] output_rsc_wadr;
    logic [DATA_W-1:0] output_rsc_d;
    logic              output_rsc_we, output_rsc_clken, output_triosy_lz;

    unet_bn_act dut (
        .clk(clk), .arst_n(arst_n), .start(start), .busy(busy), .done(done), .err(err),
        .mode(mode), .channels(channels), .height(height), .width(width),
        .in_base(in_base), .out_base(out_base),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_scale(cfg_scale), .cfg_bias(cfg_bias),
        .input_rsc_radr(input_rsc_radr), .input_rsc_re(input_rsc_re), .input_rsc_q(input_rsc_q),
        .input_rsc_clken(input_rsc_clken), .input_triosy_lz(input_triosy_lz),
        .output_rsc_wadr(output_rsc_wadr), .output_rsc_d(output_rsc_d), .output_rsc_we(output_rsc_we),
        .output_rsc_clken(output_rsc_clken), .output_triosy_lz(output_triosy_lz)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 1-cycle input SRAM
    logic [DATA_W-1:0] mem [AMOD];
    always @(posedge clk) if (input_rsc_re) input_rsc_q <= mem[input_rsc_radr];

    typedef struct { int addr; int data; int cyc; } exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   re_cnt   = 0;
    int   vx[$];
    int   vy[$];

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: count reads, check every write against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (input_rsc_re) re_cnt++;
        if (output_rsc_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", int'(output_rsc_wadr), -1);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", int'(output_rsc_wadr), e.addr);
                chk("wr_data", int'($signed(output_rsc_d)), e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic int outs_or();
        return int'(|{busy, done, err, input_rsc_re, input_rsc_clken, input_triosy_lz,
                      output_rsc_we, output_rsc_clken, output_triosy_lz,
                      input_rsc_radr, output_rsc_wadr, output_rsc_d});
    endfunction

    task automatic set_coef(input int a, input int sc, input int bi);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_addr = CH_AW'(a); cfg_scale = DATA_W'(sc); cfg_bias = DATA_W'(bi);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    // One pass: vx loaded at ib, vy expected at ob starting 4 cycles after start
    task automatic run_pass(input string tag, input int ch, input int h, input int w,
                            input int ib, input int ob, input int md, input bit exp_err,
                            input bit sc_we, input int sc_addr, input int sc_scale,
                            input int sc_bias, input bit poke);
        int n, s, exp_done;
        bit live;
        n    = ch * h * w;
        live = !exp_err && (n > 0);
        foreach (vx[i]) mem[ADDR_W'(ib + i)] = DATA_W'(vx[i]);
        @(posedge clk); #1;
        s = cyc;
        if (live) foreach (vy[i]) sb.push_back('{(ob + i) % AMOD, vy[i], s + 4 + i});
        re_cnt   = 0;
        channels = DIM_W'(ch); height = DIM_W'(h); width = DIM_W'(w);
        in_base  = ADDR_W'(ib); out_base = ADDR_W'(ob); mode = 2'(md);
        start    = 1'b1;
        if (sc_we) begin
            cfg_we = 1'b1; cfg_addr = CH_AW'(sc_addr);
            cfg_scale = DATA_W'(sc_scale); cfg_bias = DATA_W'(sc_bias);
        end
        @(posedge clk); #1;
        start  = 1'b0;
        cfg_we = 1'b0;
        chk({tag, "_busy_c1"}, int'(busy), int'(live));
        while (!done && (cyc - s) < 400) begin
            cfg_we = poke && (cyc == s + 2);
            if (cfg_we) begin
                cfg_addr = '0; cfg_scale = DATA_W'(1024); cfg_bias = '0;
            end
            @(posedge clk); #1;
        end
        cfg_we   = 1'b0;
        exp_done = live ? n + 4 : 1;
        chk({tag, "_done_cycle"}, cyc - s, exp_done);
        chk({tag, "_err"}, int'(err), int'(exp_err));
        chk({tag, "_triosy"}, int'({input_triosy_lz, output_triosy_lz}), 3);
        chk({tag, "_busy_at_done"}, int'(busy), 0);
        @(posedge clk); #1;
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_reads"}, re_cnt, live ? n : 0);
    endtask

    initial begin
        int s;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", outs_or(), 0);
        arst_n = 1'b1;

        // ReLU identity, 1x1x4
        set_coef(0, 256, 0);
        vx = '{-5, 100, 0, -2048}; vy = '{0, 100, 0, 0};
        run_pass("relu", 1, 1, 4, 10, 200, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // Saturation both ways; ch1 written in the start cycle
        set_coef(0, 512, 1000);
        vx = '{1000, -1000}; vy = '{2047, -2048};
        run_pass("sat", 2, 1, 1, 20, 300, 0, 1'b0, 1'b1, 1, 512, -1000, 1'b0);

        // Leaky ReLU
        set_coef(0, 256, 0);
        vx = '{-64, -1, 50}; vy = '{-8, -1, 50};
        run_pass("leaky", 1, 1, 3, 30, 310, 2, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // Clamped ReLU
        vx = '{1800, -7, 1000}; vy = '{1536, 0, 1000};
        run_pass("relu6", 1, 1, 3, 40, 320, 3, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // Floor on the fractional shift (scale 0.5)
        set_coef(0, 128, 0);
        vx = '{-3, 3}; vy = '{-2, 1};
        run_pass("floor", 1, 1, 2, 50, 330, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // Channel stepping, 2x2x3, no gap at the boundary
        set_coef(0, 256, 0);
        vx = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        vy = '{1, 2, 3, 4, 5, 6, 14, 16, 18, 20, 22, 24};
        run_pass("chstep", 2, 2, 3, 100, 500, 0, 1'b0, 1'b1, 1, 512, 0, 1'b0);

        // Zero-size and rejected passes
        vx = {}; vy = {};
        run_pass("zero", 0, 2, 2, 0, 0, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);
        run_pass("toobig", 65, 1, 1, 0, 0, 0, 1'b1, 1'b0, 0, 0, 0, 1'b0);

        // Address wrap with a coefficient write attempted mid-pass
        set_coef(0, 256, 5);
        vx = '{1, 2, 3, 4}; vy = '{6, 7, 8, 9};
        run_pass("wrap", 1, 2, 2, 32766, 32766, 0, 1'b0, 1'b0, 0, 0, 0, 1'b1);
        vx = '{10}; vy = '{15};
        run_pass("tab_kept", 1, 1, 1, 60, 340, 0, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        // Reset in the middle of a pass
        set_coef(0, 256, 0);
        vx = '{1, 2, 3, 4, 5, 6, 7, 8};
        foreach (vx[i]) mem[ADDR_W'(400 + i)] = DATA_W'(vx[i]);
        @(posedge clk); #1;
        s = cyc;
        sb.push_back('{600, 1, s + 4});
        channels = 7'd1; height = 7'd1; width = 7'd8;
        in_base = 15'd400; out_base = 15'd600; mode = 2'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc < s + 5) begin
            @(posedge clk); #1;
        end
        arst_n = 1'b0;
        #1;
        chk("reset_mid_outs", outs_or(), 0);
        chk("reset_mid_sb", sb.size(), 0);
        re_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        arst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_reset_reads", re_cnt, 0);
        chk("post_reset_busy", int'(busy), 0);

        // Fresh pass with new dims after reset
        set_coef(0, 256, -10);
        vx = '{5, 20, 100, -50, 10, 11}; vy = '{0, 10, 90, 0, 0, 1};
        run_pass("after_rst", 1, 2, 3, 700, 800, 1, 1'b0, 1'b0, 0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unet_bn_act.md
# unet_bn_act

Parametrised streaming batch-norm plus activation engine for the UNET IP. It reads a channel-major feature map from an input SRAM port and applies a per-channel affine transform (scale, bias) from an internal coefficient table. It then applies a selectable activation (bypass, ReLU, leaky ReLU, clamped ReLU) and writes the result to an output SRAM port at one element per cycle. It sits between convolution layers and replaces the fixed-width, ReLU-only batchnorm stage.

## Interface
- DATA_W, 12: signed element width (input, output, scale, bias)
- FRAC_W, 8: fractional bits of scale
- ADDR_W, 15: SRAM address width
- DIM_W, 7: width of channels/height/width
- CH_MAX, 64: coefficient table depth; CH_AW = clog2(CH_MAX)
- clk  in  1  clock, rising edge
- arst_n  in  1  asynchronous active-low reset
- start  in  1  begin a pass; sampled in IDLE only
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- err  out  1  last pass rejected (channels > CH_MAX); held until next accepted start
- mode  in  2  0 bypass, 1 ReLU, 2 leaky ReLU (>>>3), 3 ReLU clamped to 6.0
- channels, height, width  in  DIM_W  map dimensions, sampled at start
- in_base, out_base  in  ADDR_W  base addresses, sampled at start
- cfg_we  in  1  coefficient write strobe
- cfg_addr  in  CH_AW  channel index
- cfg_scale, cfg_bias  in  DATA_W  signed scale (Q.FRAC_W) and bias (same format as data)
- input_rsc_radr  out  ADDR_W; input_rsc_re  out  1; input_rsc_q  in  DATA_W; input_rsc_clken  out  1 (= re)
- input_triosy_lz  out  1  pulses with done
- output_rsc_wadr  out  ADDR_W; output_rsc_d  out  DATA_W; output_rsc_we  out  1; output_rsc_clken  out  1 (= we)
- output_triosy_lz  out  1  pulses with done

## Operation
- FSM states:
  - IDLE: on start, latch mode, dims and bases; compute N = channels*height*width.
    - channels > CH_MAX: go to DONE with err=1.
    - N == 0: go to DONE with err=0.
    - Otherwise: go to RUN with err=0.
  - RUN: issue one read per cycle at in_base+k, k = 0..N-1. After the last read, go to DRAIN.
  - DRAIN: 3 cycles while the pipeline empties, then go to DONE.
  - DONE: pulse done and both triosy_lz for one cycle, then go to IDLE.
- Channel index is c = k / (height*width). Maintain it with a pixel counter and a channel counter; no divider.
- Write address for element k is out_base+k. Addresses wrap modulo 2^ADDR_W.
- Arithmetic:
  - p = x*scale[c], full 2*DATA_W signed product.
  - y = sat_DATA_W((p >>> FRAC_W) + sext(bias)). The shift floors (rounds toward negative infinity).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Activation is applied to the saturated y:
  - Mode 0: y unchanged.
  - Mode 1: max(y, 0).
  - Mode 2: y<0 ? y>>>3 : y.
  - Mode 3: min(max(y, 0), 6<<FRAC_W).
- Coefficient table:
  - cfg_we writes are accepted only in IDLE and are ignored while busy.
  - A write in the same cycle as an accepted start is visible to the pass.
- start while busy is ignored.
- Asynchronous reset mid-pass aborts the pass. No further reads or writes occur.
- The coefficient table is not reset; its contents are undefined until written.

## Timing
- Reset value of every output is 0.
- Start sampled at cycle 0 produces the following:
  - Read k is issued at cycle 1+k.
  - input_rsc_q for read k is valid at cycle 2+k (1-cycle SRAM).
  - The product is registered at the end of cycle 2+k.
  - The activated result is registered at the end of cycle 3+k.
  - Write k (we, wadr, d) is presented at cycle 4+k.
- Latency from read to write is 3 cycles; throughput is 1 element per cycle with no bubbles, including across channel boundaries.
- busy is 1 in cycles 1..N+3. done (and both triosy_lz) is 1 at cycle N+4 with busy=0.
- A new start is accepted at cycle N+5.
- Rejected or zero-size pass: done at cycle 1, busy stays 0, and no re or we is issued.

## Structure
- Package unet_bn_pkg holds:
  - mode encodings and the FSM state enum;
  - the saturation function;
  - the constant RELU6_Q = 6<<FRAC_W.
- Sub-module unet_bn_datapath holds the 2-stage multiply, bias/saturate and activation pipeline. It takes valid, channel and address sideband signals through the pipeline.
- The top level holds the FSM, counters, coefficient table and SRAM port logic.

## Test plan
- ReLU identity: scale=256, bias=0, mode 1, 1x1x4 map of {-5, 100, 0, -2048} -> writes {0, 100, 0, 0}, done at cycle 8.
- Saturation:
  - scale=512, bias=1000, x=1000, mode 0 -> 2047.
  - scale=512, bias=-1000, x=-1000, mode 0 -> -2048.
- Activation modes:
  - Leaky ReLU (mode 2), x=-64, scale=256, bias=0 -> -8.
  - Clamped ReLU (mode 3), x=1800 -> 1536.
- Channel stepping: channels=2, H=2, W=3, in_base=100, out_base=500, ch0 scale 256, ch1 scale 512 -> 12 consecutive writes to 500..511. Elements 6..11 are doubled; no gap at the channel boundary.
- Boundaries:
  - channels=0 -> done at cycle 1, no SRAM access.
  - channels=CH_MAX+1 -> err=1, done at cycle 1.
  - out_base=32766 with N=4 -> writes wrap to 32766, 32767, 0, 1.
- Reset mid-pass: assert arst_n low at cycle 5 -> all outputs 0 immediately. After release, start with new dims -> correct pass. cfg_we while busy -> table unchanged.
